// File: rtl/storage_spi_responder.sv
// SPI target emulating a 25xx-style boot EEPROM, oversampled on i_clk and
// backed by a byte-wide synchronous RAM port.
module storage_spi_responder #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned SYNC_LEN = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_SCK,
    input  logic              i_SCS,
    input  logic              i_SDI,
    output logic              o_SDO,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic [7:0]        o_memWrData,
    output logic              o_memWr,
    output logic              o_memRd,
    input  logic [7:0]        i_memRdData,
    output logic              o_wel,
    output logic              o_busy
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, STATUS, IGNORE} state_t;

    state_t              state;
    logic [SYNC_LEN-1:0] sckSync, scsSync, sdiSync;
    logic                sckDly, scsDly;
    logic [3:0]          bitCnt;
    logic [14:0]         shiftIn;
    logic [7:0]          txShift;
    logic [ADDR_W-1:0]   addr;
    logic                isWrite;
    logic                loadPending;

    logic        sckS, scsS, sdiS;
    logic        sckRise, sckFall, scsRise, scsFall;
    logic [15:0] shiftNext;

    assign sckS      = sckSync[SYNC_LEN-1];
    assign scsS      = scsSync[SYNC_LEN-1];
    assign sdiS      = sdiSync[SYNC_LEN-1];
    assign sckRise   = sckS & ~sckDly;
    assign sckFall   = ~sckS & sckDly;
    assign scsRise   = scsS & ~scsDly;
    assign scsFall   = ~scsS & scsDly;
    assign shiftNext = {shiftIn, sdiS};
    assign o_busy    = (state != IDLE);

    // Synchronizers reset low so a frame already in progress at reset release
    // produces no SCS fall and is ignored until SCS deasserts.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sckSync <= '0;
            scsSync <= '0;
            sdiSync <= '0;
            sckDly  <= 1'b0;
            scsDly  <= 1'b0;
        end else begin
            sckSync[0] <= i_SCK;
            scsSync[0] <= i_SCS;
            sdiSync[0] <= i_SDI;
            for (int unsigned i = 1; i < SYNC_LEN; i++) begin
                sckSync[i] <= sckSync[i-1];
                scsSync[i] <= scsSync[i-1];
                sdiSync[i] <= sdiSync[i-1];
            end
            sckDly <= sckS;
            scsDly <= scsS;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= IDLE;
            bitCnt      <= '0;
            shiftIn     <= '0;
            txShift     <= '0;
            addr        <= '0;
            isWrite     <= 1'b0;
            loadPending <= 1'b0;
            o_SDO       <= 1'b0;
            o_memAddr   <= '0;
            o_memWrData <= '0;
            o_memWr     <= 1'b0;
            o_memRd     <= 1'b0;
            o_wel       <= 1'b0;
        end else begin
            o_memRd     <= 1'b0;
            o_memWr     <= 1'b0;
            loadPending <= o_memRd;
            if (scsRise) begin
                if ((state == ADDR && isWrite) || state == WDATA)
                    o_wel <= 1'b0;
                state   <= IDLE;
                o_SDO   <= 1'b0;
                bitCnt  <= '0;
                isWrite <= 1'b0;
            end else if (scsFall) begin
                if (state == IDLE) begin
                    state  <= CMD;
                    bitCnt <= '0;
                end
            end else begin
                if (sckRise) begin
                    shiftIn <= shiftNext[14:0];
                    bitCnt  <= bitCnt + 4'd1;
                    case (state)
                        CMD: if (bitCnt == 4'd7) begin
                            bitCnt <= '0;
                            case (shiftNext[7:0])
                                8'h03: begin
                                    state   <= ADDR;
                                    isWrite <= 1'b0;
                                end
                                8'h02: begin
                                    state   <= o_wel ? ADDR : IGNORE;
                                    isWrite <= o_wel;
                                end
                                8'h06: begin
                                    o_wel <= 1'b1;
                                    state <= IGNORE;
                                end
                                8'h04: begin
                                    o_wel <= 1'b0;
                                    state <= IGNORE;
                                end
                                8'h05: begin
                                    state   <= STATUS;
                                    txShift <= {6'b0, o_wel, 1'b0};
                                end
                                default: state <= IGNORE;
                            endcase
                        end
                        ADDR: if (bitCnt == 4'd15) begin
                            bitCnt <= '0;
                            addr   <= shiftNext[ADDR_W-1:0];
                            if (isWrite) begin
                                state <= WDATA;
                            end else begin
                                state     <= RDATA;
                                o_memRd   <= 1'b1;
                                o_memAddr <= shiftNext[ADDR_W-1:0];
                            end
                        end
                        RDATA: if (bitCnt == 4'd7) begin
                            bitCnt    <= '0;
                            o_memRd   <= 1'b1;
                            o_memAddr <= addr;
                        end
                        WDATA: if (bitCnt == 4'd7) begin
                            bitCnt      <= '0;
                            o_memWr     <= 1'b1;
                            o_memAddr   <= addr;
                            o_memWrData <= shiftNext[7:0];
                            addr        <= addr + 1'b1;
                        end
                        STATUS: if (bitCnt == 4'd7) begin
                            bitCnt  <= '0;
                            txShift <= {6'b0, o_wel, 1'b0};
                        end
                        default: bitCnt <= '0;
                    endcase
                end
                if (sckFall && (state == RDATA || state == STATUS)) begin
                    o_SDO   <= txShift[7];
                    txShift <= {txShift[6:0], 1'b0};
                end
                // RAM data arrives the cycle after o_memRd; present bit7 at
                // once if SCK is already low, otherwise wait for the fall.
                if (loadPending && state == RDATA) begin
                    addr <= addr + 1'b1;
                    if (!sckS) begin
                        o_SDO   <= i_memRdData[7];
                        txShift <= {i_memRdData[6:0], 1'b0};
                    end else begin
                        txShift <= i_memRdData;
                    end
                end
            end
        end
    end

endmodule
